// File: rtl/evt_pkg.sv
// Shared types and sizing constants for the event burst generator.
package evt_pkg;

   // Burst controller states
   typedef enum logic [1:0] {IDLE, RUN, DONE} evt_burst_state_t;

   // Default limits: events per burst and cycle spacing between events
   localparam int DEF_MAX_COUNT  = 128;
   localparam int DEF_MAX_PERIOD = 256;

   // Counter widths wide enough to hold the limits themselves
   localparam int DEF_CW = $clog2(DEF_MAX_COUNT + 1);
   localparam int DEF_PW = $clog2(DEF_MAX_PERIOD + 1);

endpackage

// File: rtl/evt_period_timer.sv
// Loadable down-counter used as the inter-event phase counter.
// A load has priority over a decrement. The count stops at zero, and the
// zero flag is decoded from the register only.
module evt_period_timer #(
   parameter int PW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          en,
   input  logic [PW-1:0] load_val,
   output logic          zero
);

   logic [PW-1:0] cnt_reg;

   // Phase register: reset to zero, then load, then count down to zero
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (en && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign zero = (cnt_reg == '0);

endmodule

// File: rtl/evt_burst_gen.sv
// Event burst generator. It emits count one-cycle evt_out strobes spaced
// period cycles apart, and then pulses done_out for one cycle.
// Optional feature macro: EVT_BURST_GEN_REPEAT_EN. When it is defined, the
// repeat_in port makes the burst restart seamlessly after its last event.
module evt_burst_gen
   import evt_pkg::*;
#(
   parameter int MAX_COUNT  = DEF_MAX_COUNT,
   parameter int MAX_PERIOD = DEF_MAX_PERIOD,
   localparam int CW = $clog2(MAX_COUNT + 1),
   localparam int PW = $clog2(MAX_PERIOD + 1)
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          start_in,
   input  logic [CW-1:0] count_in,
   input  logic [PW-1:0] period_in,
   input  logic          abort_in,
`ifdef EVT_BURST_GEN_REPEAT_EN
   input  logic          repeat_in,
`endif
   output logic          evt_out,
   output logic          busy_out,
   output logic          done_out,
   output logic [CW-1:0] remaining_out
);

   localparam logic [CW-1:0] SAT_COUNT  = CW'(MAX_COUNT);
   localparam logic [PW-1:0] SAT_PERIOD = PW'(MAX_PERIOD);
   localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
   localparam logic [PW-1:0] ONE_PERIOD = PW'(1);

   evt_burst_state_t state_reg, state_next;
   logic [CW-1:0]    remaining_reg, remaining_next;
   logic [PW-1:0]    period_reg, period_next;
   logic             done_reg, done_next;

   logic [CW-1:0]    count_sat;
   logic [PW-1:0]    period_sat;
   logic             timer_load, timer_en, phase_zero, evt;
   logic [PW-1:0]    timer_val;
   logic             rpt;
   logic [CW-1:0]    reload_val;

   // Clamp request fields to their legal range. A period of 0 behaves as 1.
   always_comb begin
      count_sat  = (count_in > SAT_COUNT) ? SAT_COUNT : count_in;
      period_sat = period_in;
      if (period_in == '0) begin
         period_sat = ONE_PERIOD;
      end else if (period_in > SAT_PERIOD) begin
         period_sat = SAT_PERIOD;
      end
   end

`ifdef EVT_BURST_GEN_REPEAT_EN
   logic [CW-1:0] count_reg;

   // Keep the accepted burst length so that repeated bursts can reload it
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         count_reg <= '0;
      end else if ((state_reg == IDLE) && start_in) begin
         count_reg <= count_sat;
      end
   end

   assign rpt        = repeat_in;
   assign reload_val = count_reg;
`else
   assign rpt        = 1'b0;
   assign reload_val = '0;
`endif

   // Phase counter: an event fires whenever it reads zero during RUN
   evt_period_timer #(.PW(PW)) u_phase (
      .clk      (clk_in),
      .rst      (rst_in),
      .load     (timer_load),
      .en       (timer_en),
      .load_val (timer_val),
      .zero     (phase_zero)
   );

   assign evt = (state_reg == RUN) && phase_zero;

   // Next-state and datapath control for the burst FSM
   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      period_next    = period_reg;
      done_next      = 1'b0;
      timer_load     = 1'b0;
      timer_en       = 1'b0;
      timer_val      = '0;
      case (state_reg)
         IDLE: begin
            if (start_in) begin
               timer_load = 1'b1;
               if (count_sat == '0) begin
                  state_next = DONE;
                  done_next  = 1'b1;
               end else begin
                  state_next     = RUN;
                  remaining_next = count_sat;
                  period_next    = period_sat;
               end
            end
         end
         RUN: begin
            if (abort_in) begin
               // The event in this cycle, if any, has already been emitted
               state_next     = IDLE;
               remaining_next = '0;
            end else if (evt) begin
               timer_load = 1'b1;
               timer_val  = period_reg - ONE_PERIOD;
               if (remaining_reg == ONE_COUNT) begin
                  done_next = 1'b1;
                  if (rpt) begin
                     remaining_next = reload_val;
                  end else begin
                     state_next     = DONE;
                     remaining_next = '0;
                  end
               end else begin
                  remaining_next = remaining_reg - ONE_COUNT;
               end
            end else begin
               timer_en = 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_reg     <= IDLE;
         remaining_reg <= '0;
         period_reg    <= ONE_PERIOD;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         period_reg    <= period_next;
         done_reg      <= done_next;
      end
   end

   assign evt_out       = evt;
   assign busy_out      = (state_reg == RUN);
   assign done_out      = done_reg;
   assign remaining_out = remaining_reg;

endmodule
